mem_access_seq: RTL and testbench
=================================

// Module: mem_access_seq
// PURPOSE
//  Load/store sequencer between the core's memory stage and the 8-bit-wide,
//  256-deep data memory. Takes one 8- or 16-bit load/store request via a
//  valid/ready handshake and splits it into single-byte memory cycles.
//  Drives MemWrite/MemRead/Byte/DataAddress/DataIn; merges DataOut into a
//  16-bit result returned on a valid/ready response channel.
// PARAMETERS
//  ADDR_W   8  memory address width; word high byte at A, low at A+1
//  WRAP_EN  1  1: A+1 wraps mod 2^ADDR_W; 0: word access at A=2^ADDR_W-1 -> RespErr
// PORTS
//  Clk          in   1       clock, all state updates on rising edge
//  Reset        in   1       async, active-low reset (0 = reset asserted)
//  ReqValid     in   1       request present
//  ReqReady     out  1       request accepted when ReqValid&ReqReady
//  ReqWrite     in   1       1 store, 0 load
//  ReqWord      in   1       1 16-bit access, 0 8-bit access
//  ReqSext      in   1       byte load only: sign-extend to 16 bits
//  ReqAddr      in   ADDR_W  byte address
//  ReqWData     in   16      store data (byte store uses [7:0])
//  RespValid    out  1       response present; held until RespReady
//  RespReady    in   1       response consumed when RespValid&RespReady
//  RespData     out  16      load result; 16'h0000 for stores and errors
//  RespErr      out  1       access rejected (WRAP_EN=0 boundary), no memory cycle
//  MemWrite     out  1       memory write strobe
//  MemRead      out  1       memory read enable
//  Byte         out  1       1 high-byte lane (DataIn[15:8] / DataOut[15:8]), 0 low lane
//  DataAddress  out  ADDR_W  memory byte address
//  DataIn       out  16      memory write data / read merge data
//  DataOut      in   16      memory read data (combinational)
// BEHAVIOUR
//  Reset (Reset=0, async): state IDLE; RespValid=0, RespErr=0, RespData=0;
//   MemWrite=MemRead=Byte=0, DataAddress=0, DataIn=0; hold reg=0. ReqReady=0
//   while Reset=0, 1 in IDLE afterwards.
//  FSM: IDLE, HI, LO, RESP. Req fields latched on accept.
//  IDLE: ReqReady=1. Accept: word & !err -> HI; byte -> LO (addr A);
//   err -> RESP with RespErr=1, no memory strobe.
//  HI: addr A, Byte=1. Store: MemWrite=1, DataIn=WData. Load: MemRead=1,
//   DataIn=0, hold[15:8] <= DataOut[15:8]. -> LO (addr A+1, wrap per WRAP_EN).
//  LO: Byte=0. Store: MemWrite=1, DataIn=WData (byte lane [7:0]). Load:
//   MemRead=1, DataIn={hold[15:8],8'h00}; word: RespData<=DataOut; byte:
//   RespData<={8{ReqSext&DataOut[7]}},DataOut[7:0]}. -> RESP.
//  RESP: RespValid=1, RespData/RespErr stable; RespReady=1 -> IDLE, RespValid
//   falls next cycle. ReqReady=0 in HI/LO/RESP (one outstanding request).
//  Memory outputs are 0 in IDLE and RESP; exactly one strobe per HI/LO cycle.
//  Latency (accept edge T): word RespValid at T+3, byte at T+2, err at T+1.
//  Address arithmetic ADDR_W bits, unsigned; A=8'hFF with WRAP_EN=1 -> low byte at 8'h00.
//  Reset mid-operation: immediate abort to IDLE, response dropped; a word store
//   aborted after HI leaves Core[A] updated and Core[A+1] unchanged (accepted).
//  ReqValid in non-IDLE states is ignored (not accepted, not lost by requester).
// TESTING
//  1 word store A=8'h10 D=16'hBEEF, then word load 8'h10 -> Core[10]=BE,
//    Core[11]=EF; load RespData=16'hBEEF at T+3, RespErr=0.
//  2 byte load 8'h11 ReqSext=1 after step 1 -> RespData=16'hFFEF; ReqSext=0 -> 16'h00EF.
//  3 word store A=8'hFF D=16'h1234, WRAP_EN=1 -> Core[FF]=12, Core[00]=34; WRAP_EN=0
//    -> RespErr=1 at T+1, no MemWrite pulse, RespData=0.
//  4 hold RespReady=0 for 5 cycles in RESP -> RespValid/RespData stable, ReqReady=0,
//    ReqValid ignored; release -> IDLE, next request accepted.
//  5 assert Reset=0 during LO of word store -> all outputs 0 immediately, FSM IDLE;
//    after release word load at A returns {WData[15:8], old Core[A+1]}.
//  6 back-to-back byte stores with RespReady tied 1 -> one request per 3 cycles,
//    one MemWrite pulse each, correct addresses.

Source files
------------

// File: rtl/mem_access_seq_if.sv
// Request/response and byte-wide memory bus for the load/store sequencer.
// The sequencer sits on the slave side; the core and memory model on the master side.
interface mem_access_seq_if #(
    parameter int ADDR_W = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic              ReqWord;
    logic              ReqSext;
    logic [ADDR_W-1:0] ReqAddr;
    logic [15:0]       ReqWData;
    logic              RespValid;
    logic              RespReady;
    logic [15:0]       RespData;
    logic              RespErr;
    logic              MemWrite;
    logic              MemRead;
    logic              Byte;
    logic [ADDR_W-1:0] DataAddress;
    logic [15:0]       DataIn;
    logic [15:0]       DataOut;

    modport slave (
        input  ReqValid, ReqWrite, ReqWord, ReqSext,
        input  ReqAddr, ReqWData, RespReady, DataOut,
        output ReqReady, RespValid, RespData, RespErr,
        output MemWrite, MemRead, Byte, DataAddress, DataIn
    );

    modport master (
        output ReqValid, ReqWrite, ReqWord, ReqSext,
        output ReqAddr, ReqWData, RespReady, DataOut,
        input  ReqReady, RespValid, RespData, RespErr,
        input  MemWrite, MemRead, Byte, DataAddress, DataIn
    );
endinterface

// File: rtl/mem_access_seq.sv
// Load/store sequencer: splits 8/16-bit requests into byte memory cycles,
// high byte at A then low byte at A+1, and returns a merged 16-bit result.
module mem_access_seq #(
    parameter int ADDR_W  = 8,
    parameter bit WRAP_EN = 1'b1
) (
    input logic             Clk,
    input logic             Reset,
    mem_access_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              word_q, word_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        hold_q, hold_d;
    logic [15:0]       resp_q, resp_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] addr_lo;

    assign accept  = bus.ReqValid && bus.ReqReady;
    // A word at the top address has no A+1 unless wrapping is allowed.
    assign req_err = bus.ReqWord && !WRAP_EN && (&bus.ReqAddr);
    assign addr_lo = word_q ? addr_q + ADDR_W'(1) : addr_q;

    // State register; reset aborts any access in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one outstanding request, walked through HI/LO to RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)          state_d = RESP;
                    else if (bus.ReqWord) state_d = HI;
                    else                  state_d = LO;
                end
            end
            HI:      state_d = LO;
            LO:      state_d = RESP;
            RESP:    if (bus.RespReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory bus driven only in HI/LO, one strobe per cycle.
    always_comb begin
        bus.ReqReady    = 1'b0;
        bus.RespValid   = 1'b0;
        bus.RespData    = resp_q;
        bus.RespErr     = err_q;
        bus.MemWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.Byte        = 1'b0;
        bus.DataAddress = '0;
        bus.DataIn      = 16'h0000;
        unique case (state_q)
            IDLE: bus.ReqReady = Reset;
            HI: begin
                bus.MemWrite    = write_q;
                bus.MemRead     = !write_q;
                bus.Byte        = 1'b1;
                bus.DataAddress = addr_q;
                bus.DataIn      = write_q ? wdata_q : 16'h0000;
            end
            LO: begin
                bus.MemWrite    = write_q;
                bus.MemRead     = !write_q;
                bus.DataAddress = addr_lo;
                bus.DataIn      = write_q ? wdata_q : {hold_q, 8'h00};
            end
            RESP:    bus.RespValid = 1'b1;
            default: bus.ReqReady  = 1'b0;
        endcase
    end

    // Datapath next-state: latch request, capture high byte, build result.
    always_comb begin
        write_d = write_q;
        word_d  = word_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        resp_d  = resp_q;
        err_d   = err_q;
        if (accept) begin
            write_d = bus.ReqWrite;
            word_d  = bus.ReqWord;
            sext_d  = bus.ReqSext;
            addr_d  = bus.ReqAddr;
            wdata_d = bus.ReqWData;
            err_d   = req_err;
            resp_d  = 16'h0000;
        end
        if (state_q == HI && !write_q) begin
            hold_d = bus.DataOut[15:8];
        end
        if (state_q == LO && !write_q) begin
            if (word_q) resp_d = bus.DataOut;
            else        resp_d = {{8{sext_q & bus.DataOut[7]}},
                                  bus.DataOut[7:0]};
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            write_q <= 1'b0;
            word_q  <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            hold_q  <= 8'h00;
            resp_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            word_q  <= word_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: wrapping and non-wrapping instances,
// each with a byte-wide memory model that merges DataIn on low-lane reads.
module tb_mem_access_seq;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        v;
        logic        w;
        logic        word;
        logic        sext;
        logic [7:0]  a;
        logic [15:0] d;
    } req_t;

    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic        err;
        logic [15:0] rd;
        logic        mw;
        logic        mr;
        logic        by;
        logic [7:0]  da;
        logic [15:0] di;
    } obs_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    req_t       rq [2];
    logic       rr [2];
    obs_t       ob [2];
    logic [7:0] core [2][256];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         mwa = 0;
    int         mwb = 0;

    mem_access_seq_if #(.ADDR_W(8)) ifa ();
    mem_access_seq_if #(.ADDR_W(8)) ifb ();

    mem_access_seq #(.ADDR_W(8), .WRAP_EN(1'b1)) u_a (
        .Clk(Clk), .Reset(Reset), .bus(ifa)
    );
    mem_access_seq #(.ADDR_W(8), .WRAP_EN(1'b0)) u_b (
        .Clk(Clk), .Reset(Reset), .bus(ifb)
    );

    assign ifa.ReqValid  = rq[0].v;
    assign ifa.ReqWrite  = rq[0].w;
    assign ifa.ReqWord   = rq[0].word;
    assign ifa.ReqSext   = rq[0].sext;
    assign ifa.ReqAddr   = rq[0].a;
    assign ifa.ReqWData  = rq[0].d;
    assign ifa.RespReady = rr[0];
    assign ifb.ReqValid  = rq[1].v;
    assign ifb.ReqWrite  = rq[1].w;
    assign ifb.ReqWord   = rq[1].word;
    assign ifb.ReqSext   = rq[1].sext;
    assign ifb.ReqAddr   = rq[1].a;
    assign ifb.ReqWData  = rq[1].d;
    assign ifb.RespReady = rr[1];

    assign ob[0] = {ifa.ReqReady, ifa.RespValid, ifa.RespErr, ifa.RespData,
                    ifa.MemWrite, ifa.MemRead, ifa.Byte, ifa.DataAddress,
                    ifa.DataIn};
    assign ob[1] = {ifb.ReqReady, ifb.RespValid, ifb.RespErr, ifb.RespData,
                    ifb.MemWrite, ifb.MemRead, ifb.Byte, ifb.DataAddress,
                    ifb.DataIn};

    // High lane returns the byte in [15:8]; low lane merges DataIn[15:8].
    assign ifa.DataOut = ifa.Byte ? {core[0][ifa.DataAddress], 8'h00}
                                  : {ifa.DataIn[15:8], core[0][ifa.DataAddress]};
    assign ifb.DataOut = ifb.Byte ? {core[1][ifb.DataAddress], 8'h00}
                                  : {ifb.DataIn[15:8], core[1][ifb.DataAddress]};

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (ifa.MemWrite) begin
            mwa <= mwa + 1;
            core[0][ifa.DataAddress] <= ifa.Byte ? ifa.DataIn[15:8] : ifa.DataIn[7:0];
        end
        if (ifb.MemWrite) begin
            mwb <= mwb + 1;
            core[1][ifb.DataAddress] <= ifb.Byte ? ifb.DataIn[15:8] : ifb.DataIn[7:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One request on DUT s from a falling edge with the DUT idle; the
    // expected response goes into the scoreboard and is popped on arrival.
    task automatic send(input int s, input bit wr, input bit word, input bit sext,
                        input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] ed, input bit ee, input int el,
                        input int hold);
        exp_t        e;
        int          lat;
        logic [15:0] snap;
        sb.push_back('{ed, ee, el});
        rr[s] = (hold == 0);
        rq[s] = '{1'b1, wr, word, sext, a, d};
        chk("req_ready_idle", ob[s].rdy, 1);
        @(posedge Clk);
        #1 rq[s].v = 1'b0;
        lat = 1;
        @(negedge Clk);
        while (!ob[s].rv && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("resp_data", ob[s].rd, e.data);
        chk("resp_err", ob[s].err, e.err);
        chk("req_ready_busy", ob[s].rdy, 0);
        if (hold > 0) begin
            snap = ob[s].rd;
            rq[s] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 16'h0099};
            repeat (hold) begin
                @(negedge Clk);
                chk("hold_valid", ob[s].rv, 1);
                chk("hold_data", ob[s].rd, snap);
                chk("hold_ready", ob[s].rdy, 0);
            end
            rq[s].v = 1'b0;
            rr[s] = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
        chk("resp_valid_fall", ob[s].rv, 0);
        chk("req_ready_again", ob[s].rdy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc [4];
        int mw0;
        int g;
        for (int i = 0; i < 256; i++) begin
            core[0][i] = 8'h00;
            core[1][i] = 8'h00;
        end
        rq[0] = '0;
        rq[1] = '0;
        rr[0] = 1'b1;
        rr[1] = 1'b1;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_outs_a", ob[0], 0);
        chk("reset_outs_b", ob[1], 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("ready_after_reset", ob[0].rdy, 1);

        // word store then word load, high byte at A
        send(0, 1, 1, 0, 8'h10, 16'hBEEF, 16'h0000, 0, 3, 0);
        chk("core10", core[0][8'h10], 8'hBE);
        chk("core11", core[0][8'h11], 8'hEF);
        send(0, 0, 1, 0, 8'h10, 16'h0000, 16'hBEEF, 0, 3, 0);

        // byte loads with and without sign extension
        send(0, 0, 0, 1, 8'h11, 16'h0000, 16'hFFEF, 0, 2, 0);
        send(0, 0, 0, 0, 8'h11, 16'h0000, 16'h00EF, 0, 2, 0);
        send(0, 0, 0, 1, 8'h10, 16'h0000, 16'hFFBE, 0, 2, 0);

        // top-address word: wraps on A, rejected on B
        send(0, 1, 1, 0, 8'hFF, 16'h1234, 16'h0000, 0, 3, 0);
        chk("coreFF_wrap", core[0][8'hFF], 8'h12);
        chk("core00_wrap", core[0][8'h00], 8'h34);
        send(0, 0, 1, 0, 8'hFF, 16'h0000, 16'h1234, 0, 3, 0);
        send(1, 1, 1, 0, 8'hFF, 16'h1234, 16'h0000, 1, 1, 0);
        chk("nowrap_no_write", mwb, 0);
        chk("nowrap_coreFF", core[1][8'hFF], 8'h00);
        send(1, 0, 1, 0, 8'hFF, 16'h0000, 16'h0000, 1, 1, 0);
        send(1, 1, 0, 0, 8'hFF, 16'h00A7, 16'h0000, 0, 2, 0);
        chk("nowrap_byte_store", core[1][8'hFF], 8'hA7);
        chk("nowrap_one_write", mwb, 1);

        // response held for 5 cycles, stray request ignored
        send(0, 0, 0, 0, 8'h10, 16'h0000, 16'h00BE, 0, 2, 5);
        chk("stray_not_written", core[0][8'h80], 8'h00);
        send(0, 0, 0, 0, 8'h11, 16'h0000, 16'h00EF, 0, 2, 0);

        // reset during LO of a word store
        send(0, 1, 0, 0, 8'h21, 16'h0077, 16'h0000, 0, 2, 0);
        rq[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 16'hA55A};
        @(posedge Clk);
        #1 rq[0].v = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("lo_addr", ob[0].da, 8'h21);
        chk("lo_write", ob[0].mw, 1);
        Reset = 1'b0;
        #1;
        chk("abort_outs", ob[0], 0);
        @(negedge Clk);
        chk("abort_core20", core[0][8'h20], 8'hA5);
        chk("abort_core21", core[0][8'h21], 8'h77);
        Reset = 1'b1;
        @(negedge Clk);
        send(0, 0, 1, 0, 8'h20, 16'h0000, 16'hA577, 0, 3, 0);

        // back-to-back byte stores with RespReady held high
        rr[0] = 1'b1;
        mw0 = mwa;
        for (int k = 0; k < 4; k++) begin
            rq[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h40 + 8'(k), 16'h00C0 + 16'(k)};
            g = 0;
            while (!ob[0].rdy && g < 10) begin
                @(negedge Clk);
                g++;
            end
            @(posedge Clk);
            #1 acc[k] = cyc;
            @(negedge Clk);
        end
        rq[0].v = 1'b0;
        repeat (4) @(negedge Clk);
        for (int k = 1; k < 4; k++) begin
            chk("b2b_gap", acc[k] - acc[k-1], 3);
        end
        chk("b2b_writes", mwa - mw0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_core", core[0][8'h40 + k], 8'hC0 + 8'(k));
        end
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
